stream_demux_1_4: RTL and testbench
===================================

STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of every channel.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream item present.
REQ-005 SHALL have port in_ready  output  1  demux accepts item this cycle.
REQ-006 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-007 SHALL have port in_sel  input  2  destination channel index 0..3; qualified by in_valid.
REQ-008 SHALL have ports out_valid  output  4  one bit per channel, item held in channel buffer.
REQ-009 SHALL have ports out_ready  input  4  one bit per channel, downstream consumes.
REQ-010 SHALL have ports d0, d1, d2, d3  output  WIDTH each  channel payloads, registered.
REQ-011 SHALL have port cnt  output  4x8 (cnt0..cnt3) present only with DEMUX_COUNT_EN, per-channel delivered-item count.

Function
REQ-012 SHALL hold a one-entry buffer per channel, each with states EMPTY and FULL; out_valid[i] = (state i == FULL).
REQ-013 SHALL signal input transfer when in_valid && in_ready; output transfer on channel i when out_valid[i] && out_ready[i].
REQ-014 SHALL drive in_ready = (buffer[in_sel] EMPTY) || out_ready[in_sel]; combinational, in_ready depends on in_sel, not on in_valid.
REQ-015 SHALL, on input transfer, write in_data into buffer in_sel and set it FULL on the next edge; latency input->out_valid exactly 1 cycle.
REQ-016 SHALL, on output transfer without simultaneous input to the same channel, set that channel EMPTY.
REQ-017 SHALL, on simultaneous output and input transfer on the same channel, stay FULL and load the new item (no bubble, full throughput).
REQ-018 SHALL leave channels other than in_sel unaffected by input transfers; all four channels may drain in the same cycle.
REQ-019 SHALL keep d[i] stable while out_valid[i]=1 and out_ready[i]=0 (no overwrite, in_ready low for that sel).
REQ-020 SHALL preserve per-channel ordering; items to different channels carry no mutual ordering.
REQ-021 SHALL ignore in_sel and in_data when in_valid=0; X on them with in_valid=0 SHALL NOT alter state.
REQ-022 SHALL never drop or duplicate an item: items out of channel i equal items accepted with in_sel=i.

Reset
REQ-023 SHALL, while rst=1, force all buffers EMPTY: out_valid=4'b0000, d0..d3=0, cnt0..cnt3=0 (if present), asynchronously.
REQ-024 SHALL discard buffered items when rst asserts mid-operation; in_ready SHALL be 1 during reset for every in_sel, but no transfer is recorded while rst=1.
REQ-025 SHALL resume operation on the first rising clk edge after rst deasserts.

Configuration
REQ-026 SHALL use macro DEMUX_COUNT_EN: defined -> ports cnt0..cnt3 exist, each 8-bit, incrementing by 1 on every output transfer of its channel, wrapping 255->0.
REQ-027 SHALL, without DEMUX_COUNT_EN, omit cnt0..cnt3 and all counter logic; all other behaviour identical.

Verification
REQ-028 SHALL cover: reset, then in_valid=1, in_sel=2, in_data=4'hc, out_ready=4'b0000 -> next cycle out_valid=4'b0100, d2=4'hc, in_ready=0 for sel 2, 1 for sel 0.
REQ-029 SHALL cover: channel 1 FULL with 4'ha, out_ready[1]=1, in_valid=1 in_sel=1 in_data=4'hb -> in_ready=1, next cycle out_valid[1]=1, d1=4'hb (back-to-back, no bubble).
REQ-030 SHALL cover: items 4'h1,4'h2,4'h3,4'h4 to channels 0,1,2,3 with out_ready=0, then out_ready=4'b1111 for one cycle -> all four delivered same cycle, out_valid=4'b0000 after.
REQ-031 SHALL cover: in_valid=0 with in_sel=2'bxx, in_data='x for 3 cycles -> out_valid unchanged, no X on outputs.
REQ-032 SHALL cover: rst pulsed asynchronously between edges with channels 0 and 3 FULL -> out_valid=0 and d0..d3=0 immediately, before the next edge.
REQ-033 SHALL cover (DEMUX_COUNT_EN): 257 items through channel 0 with out_ready[0]=1 -> cnt0=1, cnt1..cnt3=0.

Source files
------------

// File: rtl/stream_demux_1_4_if.sv
// ---------------------------------------------------------------------------
// stream_demux_1_4_if -- bundle of handshake and data signals for the
// 1-to-4 stream demultiplexer.
//
// Signals:
//   in_valid / in_ready / in_data / in_sel : upstream handshake, payload and
//                                            destination channel (0..3)
//   out_valid[3:0] / out_ready[3:0]        : per-channel downstream handshake
//   d0..d3                                 : per-channel registered payloads
//   cnt0..cnt3                             : per-channel delivered-item count
//                                            (only with DEMUX_COUNT_EN)
//
// Modports:
//   master : environment side (drives upstream data and downstream ready)
//   slave  : demux side
//
// Optional feature macro: DEMUX_COUNT_EN
// ---------------------------------------------------------------------------
interface stream_demux_1_4_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
`ifdef DEMUX_COUNT_EN
    logic [7:0]       cnt0;
    logic [7:0]       cnt1;
    logic [7:0]       cnt2;
    logic [7:0]       cnt3;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, d0, d1, d2, d3, cnt0, cnt1, cnt2, cnt3
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, d0, d1, d2, d3, cnt0, cnt1, cnt2, cnt3
    );
`else
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, d0, d1, d2, d3
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, d0, d1, d2, d3
    );
`endif
endinterface

// File: rtl/stream_demux_1_4.sv
// ---------------------------------------------------------------------------
// stream_demux_1_4 -- routes a valid/ready input stream to one of four
// output channels selected by in_sel. Each channel owns a one-entry buffer
// (EMPTY/FULL). A FULL buffer whose downstream is ready can accept a new item
// in the same cycle, so every channel sustains full throughput.
//
// Ports:
//   clk : clock, all state changes on its rising edge
//   rst : asynchronous, active-high reset; empties every buffer, clears
//         payload registers and counters
//   bus : stream_demux_1_4_if.slave (upstream handshake, per-channel
//         downstream handshake, d0..d3 payloads, optional cnt0..cnt3)
//
// Optional feature macro: DEMUX_COUNT_EN -- adds an 8-bit wrapping count of
// delivered items per channel (cnt0..cnt3).
// ---------------------------------------------------------------------------
module stream_demux_1_4 #(
    parameter int WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    stream_demux_1_4_if.slave bus
);
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic [3:0]       full_vec;
    logic [WIDTH-1:0] data_arr [4];
`ifdef DEMUX_COUNT_EN
    logic [7:0]       cnt_arr  [4];
`endif

    // Ready depends only on the addressed channel: free slot, or the slot
    // is being drained in this very cycle.
    assign bus.in_ready  = (full_vec[bus.in_sel] == ST_EMPTY) | bus.out_ready[bus.in_sel];
    assign bus.out_valid = full_vec;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic             state_reg;
            logic [WIDTH-1:0] data_reg;
            logic             in_hit;
            logic             out_hit;

            assign in_hit  = bus.in_valid & bus.in_ready & (bus.in_sel == 2'(gi));
            assign out_hit = (state_reg == ST_FULL) & bus.out_ready[gi];

            // An incoming item wins over a drain: the slot stays FULL and
            // takes the new payload, giving back-to-back transfers.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= ST_EMPTY;
                    data_reg  <= '0;
                end else if (in_hit) begin
                    state_reg <= ST_FULL;
                    data_reg  <= bus.in_data;
                end else if (out_hit) begin
                    state_reg <= ST_EMPTY;
                end
            end

            assign full_vec[gi] = state_reg;
            assign data_arr[gi] = data_reg;

`ifdef DEMUX_COUNT_EN
            logic [7:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (out_hit) begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end

            assign cnt_arr[gi] = cnt_reg;
`endif
        end
    endgenerate

    assign bus.d0 = data_arr[0];
    assign bus.d1 = data_arr[1];
    assign bus.d2 = data_arr[2];
    assign bus.d3 = data_arr[3];

`ifdef DEMUX_COUNT_EN
    assign bus.cnt0 = cnt_arr[0];
    assign bus.cnt1 = cnt_arr[1];
    assign bus.cnt2 = cnt_arr[2];
    assign bus.cnt3 = cnt_arr[3];
`endif
endmodule

// File: tb/tb_stream_demux_1_4.sv
// ---------------------------------------------------------------------------
// tb_stream_demux_1_4 -- self-checking bench for stream_demux_1_4.
// Reference model: one queue of pending items per channel; a channel is
// valid while its queue is non-empty and shows the queue head. Capacity of
// one item means an input is accepted when the queue is empty or its head
// leaves in the same cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_demux_1_4;
    logic clk;
    logic rst;

    stream_demux_1_4_if #(.WIDTH(4)) bus ();

    stream_demux_1_4 #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [3:0] mq [4][$];
    int         cnt_m [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] get_d(input int i);
        case (i)
            0:       return bus.d0;
            1:       return bus.d1;
            2:       return bus.d2;
            default: return bus.d3;
        endcase
    endfunction

`ifdef DEMUX_COUNT_EN
    function automatic logic [7:0] get_cnt(input int i);
        case (i)
            0:       return bus.cnt0;
            1:       return bus.cnt1;
            2:       return bus.cnt2;
            default: return bus.cnt3;
        endcase
    endfunction
`endif

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            cnt_m[i] = 0;
        end
    endtask

    // Compare every DUT output against the queue model.
    task automatic check_outputs();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("out_valid[%0d]", i), 32'(bus.out_valid[i]), 32'(mq[i].size() != 0));
            if (mq[i].size() != 0)
                chk($sformatf("d%0d", i), 32'(get_d(i)), 32'(mq[i][0]));
`ifdef DEMUX_COUNT_EN
            chk($sformatf("cnt%0d", i), 32'(get_cnt(i)), 32'(cnt_m[i]));
`endif
        end
    endtask

    // One clock cycle: entered and left at the falling edge.
    task automatic step(input logic v, input logic [1:0] s, input logic [3:0] dt, input logic [3:0] ordy);
        logic exp_rdy;
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = dt;
        bus.out_ready = ordy;
        #1;
        check_outputs();
        exp_rdy = 1'b0;
        if (!$isunknown(s)) begin
            exp_rdy = (mq[s].size() == 0) || ordy[s];
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (mq[i].size() != 0 && ordy[i]) begin
                void'(mq[i].pop_front());
                cnt_m[i] = (cnt_m[i] + 1) % 256;
            end
        end
        if (v === 1'b1 && exp_rdy)
            mq[s].push_back(dt);
        $display("step t=%0t valid=%b sel=%0d data=%h out_ready=%b accepted=%b", $time, v, s, dt, ordy, (v === 1'b1) && exp_rdy);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between two rising edges, checking outputs
    // while reset is held.
    task automatic pulse_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rst_d%0d", i), 32'(get_d(i)), 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.in_sel = 2'(i);
            #1;
            chk($sformatf("rst_in_ready_sel%0d", i), 32'(bus.in_ready), 32'h1);
        end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = 4'h0;
        bus.out_ready = 4'b0000;
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_d0", 32'(bus.d0), 32'h0);
        chk("reset_d3", 32'(bus.d3), 32'h0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'h1);
        rst = 1'b0;
        @(negedge clk);

        // Single item held by a stalled channel.
        step(1'b1, 2'd2, 4'hc, 4'b0000);
        bus.in_valid = 1'b0;
        bus.in_sel   = 2'd2;
        #1 chk("r028_rdy_sel2", 32'(bus.in_ready), 32'h0);
        bus.in_sel   = 2'd0;
        #1 chk("r028_rdy_sel0", 32'(bus.in_ready), 32'h1);
        chk("r028_out_valid", 32'(bus.out_valid), 32'h4);
        chk("r028_d2", 32'(bus.d2), 32'hc);
        @(negedge clk);
        step(1'b0, 2'd0, 4'h0, 4'b0100);

        // Back-to-back load while draining.
        step(1'b1, 2'd1, 4'ha, 4'b0000);
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_data   = 4'hb;
        bus.out_ready = 4'b0010;
        #1 chk("r029_rdy", 32'(bus.in_ready), 32'h1);
        step(1'b1, 2'd1, 4'hb, 4'b0010);
        chk("r029_valid1", 32'(bus.out_valid[1]), 32'h1);
        chk("r029_d1", 32'(bus.d1), 32'hb);
        step(1'b0, 2'd0, 4'h0, 4'b0010);

        // All four channels drain together.
        for (int i = 0; i < 4; i++)
            step(1'b1, 2'(i), 4'(i + 1), 4'b0000);
        chk("r030_all_full", 32'(bus.out_valid), 32'hf);
        step(1'b0, 2'd0, 4'h0, 4'b1111);
        chk("r030_all_empty", 32'(bus.out_valid), 32'h0);

        // Unknown select/data while idle must not disturb state.
        step(1'b1, 2'd2, 4'h5, 4'b0000);
        for (int k = 0; k < 3; k++)
            step(1'b0, 2'bxx, 4'bxxxx, 4'b0000);
        chk("r031_out_valid", 32'(bus.out_valid), 32'h4);
        chk("r031_known", 32'($isunknown({bus.out_valid, bus.d0, bus.d1, bus.d2, bus.d3})), 32'h0);
        step(1'b0, 2'd0, 4'h0, 4'b1111);

        // Asynchronous reset with channels 0 and 3 holding items.
        step(1'b1, 2'd0, 4'h7, 4'b0000);
        step(1'b1, 2'd3, 4'h9, 4'b0000);
        chk("r032_pre", 32'(bus.out_valid), 32'h9);
        pulse_reset();
        step(1'b1, 2'd1, 4'h6, 4'b0000);
        chk("r025_resume", 32'(bus.out_valid), 32'h2);
        step(1'b0, 2'd0, 4'h0, 4'b1111);

        // Randomised traffic against the queue model.
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        step(1'b0, 2'd0, 4'h0, 4'b1111);
        check_outputs();
        chk("drained", 32'(bus.out_valid), 32'h0);

`ifdef DEMUX_COUNT_EN
        // 257 deliveries on channel 0: counter wraps to 1.
        pulse_reset();
        for (int k = 0; k < 257; k++)
            step(1'b1, 2'd0, 4'($urandom_range(0, 15)), 4'b0001);
        step(1'b0, 2'd0, 4'h0, 4'b0001);
        check_outputs();
        chk("r033_cnt0", 32'(bus.cnt0), 32'h1);
        chk("r033_cnt123", 32'({bus.cnt1, bus.cnt2, bus.cnt3}), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
